// File: rtl/pps_sync_ctrl.sv
// pps_sync_ctrl: disciplines a local one-second counter to an external PPS,
// sequences HUNT/ACQUIRE/LOCKED/HOLDOVER and generates pps_out and tick.
module pps_sync_ctrl #(
  parameter int CLK_HZ      = 125000000,
  parameter int TOL         = 2500,
  parameter int LOCK_COUNT  = 4,
  parameter int PULSE_WIDTH = 12500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pps_in,
  input  logic [1:0]  mode,
  output logic        pps_out,
  output logic        tick,
  output logic [1:0]  state,
  output logic        locked,
  output logic [31:0] period_meas,
  output logic [7:0]  good_cnt
);
  localparam int LW = $clog2(CLK_HZ);
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam logic [31:0] P_LO = 32'(CLK_HZ - TOL);
  localparam logic [31:0] P_HI = 32'(CLK_HZ + TOL);
  localparam logic [31:0] P_TO = 32'(CLK_HZ + TOL + 1);
  localparam logic [LW-1:0] LC_MAX = LW'(CLK_HZ - 1);
  localparam logic [8:0] LOCK_N = 9'(LOCK_COUNT);
  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED, HOLDOVER} st_t;
  st_t st;
  logic [2:0] sync;
  logic pps_edge, have_prev;
  logic [31:0] pc;
  logic [LW-1:0] lc;
  logic [PW-1:0] pw;
  logic follow, good, bad, timeout, align, wrap, fire;
  assign state = st;
  always_comb begin
    follow = mode == 2'd1 || mode == 2'd2;
    good = pps_edge && have_prev && pc >= P_LO && pc <= P_HI;
    bad = pps_edge && have_prev && !good;
    timeout = !pps_edge && pc == P_TO;
    align = follow && good && (st == LOCKED || (st == ACQUIRE && {1'b0, good_cnt} + 9'd1 >= LOCK_N));
    wrap = lc == LC_MAX;
    // an align right after a wrap still re-phases lc but must not double-tick
    fire = (wrap || align) && !tick;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync <= '0;
      pps_edge <= 1'b0;
      have_prev <= 1'b0;
      pc <= '0;
      lc <= '0;
      pw <= '0;
      tick <= 1'b0;
      pps_out <= 1'b0;
      st <= HUNT;
      locked <= 1'b0;
      period_meas <= '0;
      good_cnt <= '0;
    end else begin
      sync <= {sync[1:0], pps_in};
      pps_edge <= sync[1] & ~sync[2];
      pc <= pps_edge ? 32'd1 : pc + {31'd0, pc != '1};
      if (pps_edge) period_meas <= pc;
      lc <= (wrap || align) ? '0 : lc + LW'(1);
      tick <= fire;
      pw <= fire ? PW'(PULSE_WIDTH - 1) : pw - PW'(pw != '0);
      pps_out <= (fire || pw != '0) && mode != 2'd2;
      if (!follow) begin
        st <= HUNT;
        good_cnt <= '0;
        have_prev <= 1'b0;
        locked <= 1'b0;
      end else
        case (st)
          HUNT: if (pps_edge) begin
            st <= ACQUIRE;
            good_cnt <= '0;
            have_prev <= 1'b1;
          end
          ACQUIRE: if (good) begin
            good_cnt <= good_cnt + {7'd0, good_cnt != 8'hFF};
            if (align) begin
              st <= LOCKED;
              locked <= 1'b1;
            end
          end else if (bad || timeout) begin
            st <= HUNT;
            good_cnt <= '0;
            have_prev <= 1'b0;
          end
          LOCKED: if (good) good_cnt <= good_cnt + {7'd0, good_cnt != 8'hFF};
          else if (bad || timeout) begin
            st <= HOLDOVER;
            good_cnt <= '0;
            locked <= 1'b0;
          end
          HOLDOVER: if (pps_edge) begin
            st <= ACQUIRE;
            good_cnt <= '0;
          end
        endcase
    end
endmodule

// File: tb/tb_pps_sync_ctrl.sv
// tb_pps_sync_ctrl: directed PPS scenarios; expected ticks, state changes and
// pulse widths are queued up front and matched by an independent monitor.
module tb_pps_sync_ctrl;
  logic CLK = 1'b0, RST = 1'b1, pps_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic pps_out, tick, locked;
  logic [1:0] state;
  logic [31:0] period_meas;
  logic [7:0] good_cnt;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {int cyc; logic [1:0] st; logic lk; logic [7:0] gc; logic [31:0] pm; logic po;} tick_t;
  typedef struct {int cyc; logic [1:0] st; logic [7:0] gc; logic [31:0] pm;} st_rec_t;
  tick_t tq[$];
  st_rec_t sq[$];
  int pq[$];

  pps_sync_ctrl #(.CLK_HZ(100), .TOL(2), .LOCK_COUNT(3), .PULSE_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .pps_in(pps_in), .mode(mode), .pps_out(pps_out), .tick(tick),
    .state(state), .locked(locked), .period_meas(period_meas), .good_cnt(good_cnt));

  always #5 CLK = ~CLK;
  always @(posedge CLK or posedge RST) cyc <= RST ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic et(input int c, input logic [1:0] s, input logic l, input logic [7:0] g, input logic [31:0] p, input logic o);
    tq.push_back('{c, s, l, g, p, o});
  endtask
  task automatic es(input int c, input logic [1:0] s, input logic [7:0] g, input logic [31:0] p);
    sq.push_back('{c, s, g, p});
  endtask

  // monitor
  logic [1:0] prev_st = 2'd0;
  int run = 0;
  tick_t t;
  st_rec_t s;
  int w;
  always @(negedge CLK) begin
    if (RST) begin
      prev_st = state;
      run = 0;
    end else begin
      if (tick) begin
        if (tq.size() == 0) chk("unexpected_tick", 32'(tq.size()), 32'd1);
        else begin
          t = tq.pop_front();
          chk("tick_cycle", cyc, t.cyc);
          chk("tick_state", state, t.st);
          chk("tick_locked", locked, t.lk);
          chk("tick_good_cnt", good_cnt, t.gc);
          chk("tick_period", period_meas, t.pm);
          chk("tick_pps_out", pps_out, t.po);
        end
      end
      if (state != prev_st) begin
        if (sq.size() == 0) chk("unexpected_state_change", state, prev_st);
        else begin
          s = sq.pop_front();
          chk("state_cycle", cyc, s.cyc);
          chk("state_value", state, s.st);
          chk("state_locked", locked, s.st == 2'd2);
          chk("state_good_cnt", good_cnt, s.gc);
          chk("state_period", period_meas, s.pm);
        end
      end
      prev_st = state;
      if (pps_out) run++;
      else if (run > 0) begin
        if (pq.size() == 0) chk("unexpected_pulse", run, 0);
        else begin
          w = pq.pop_front();
          chk("pulse_width", run, w);
        end
        run = 0;
      end
    end
  end

  task automatic run_to(input int k);
    while (cyc < k) @(negedge CLK);
  endtask

  task automatic edge_at(input int k);
    run_to(k - 1);
    pps_in = 1'b1;
    run_to(k + 19);
    pps_in = 1'b0;
  endtask

  task automatic drain_check();
    chk("leftover_ticks", 32'(tq.size()), 32'd0);
    chk("leftover_states", 32'(sq.size()), 32'd0);
    chk("leftover_pulses", 32'(pq.size()), 32'd0);
  endtask

  task automatic do_reset();
    drain_check();
    RST = 1'b1;
    pps_in = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  // reset, mode m, four edges 100 apart -> lock on the fourth edge at cycle 453
  task automatic lock_seq(input logic [1:0] m);
    logic p;
    p = m != 2'd2;
    mode = m;
    do_reset();
    et(100, 0, 0, 0, 0, p);
    et(200, 1, 0, 0, 152, p);
    et(300, 1, 0, 1, 100, p);
    et(400, 1, 0, 2, 100, p);
    et(453, 2, 1, 3, 100, p);
    es(153, 1, 0, 152);
    es(453, 2, 3, 100);
    if (p) repeat (5) pq.push_back(5);
    edge_at(150);
    edge_at(250);
    edge_at(350);
    edge_at(450);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: free-run, reset values then tick every 100 cycles
    mode = 2'd0;
    do_reset();
    chk("rst_pps_out", pps_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_period", period_meas, 0);
    chk("rst_good_cnt", good_cnt, 0);
    et(100, 0, 0, 0, 0, 1);
    et(200, 0, 0, 0, 0, 1);
    et(300, 0, 0, 0, 0, 1);
    repeat (3) pq.push_back(5);
    run_to(350);
    // 2+3: lock, coincident align/wrap, 102 keeps lock, 103 drops to holdover
    lock_seq(2'd1);
    et(553, 2, 1, 4, 100, 1);
    et(653, 2, 1, 4, 100, 1);
    et(655, 2, 1, 5, 102, 1);
    et(755, 2, 1, 5, 102, 1);
    et(855, 3, 0, 0, 103, 1);
    et(955, 3, 0, 0, 103, 1);
    es(758, 3, 0, 103);
    pq.push_back(5);
    pq.push_back(7);
    repeat (3) pq.push_back(5);
    edge_at(550);
    edge_at(652);
    edge_at(755);
    run_to(1000);
    // 4: lock then pps_in stops -> timeout 103 cycles after last edge
    lock_seq(2'd1);
    et(553, 2, 1, 3, 100, 1);
    et(653, 3, 0, 0, 100, 1);
    es(556, 3, 0, 100);
    repeat (2) pq.push_back(5);
    run_to(700);
    // 5: short period in ACQUIRE falls back to HUNT
    mode = 2'd1;
    do_reset();
    et(100, 0, 0, 0, 0, 1);
    et(200, 1, 0, 0, 152, 1);
    et(300, 1, 0, 1, 100, 1);
    et(400, 0, 0, 0, 97, 1);
    et(500, 1, 0, 0, 100, 1);
    et(600, 1, 0, 1, 100, 1);
    es(153, 1, 0, 152);
    es(350, 0, 0, 97);
    es(450, 1, 0, 100);
    repeat (6) pq.push_back(5);
    edge_at(150);
    edge_at(250);
    edge_at(347);
    edge_at(447);
    edge_at(547);
    edge_at(647);
    run_to(690);
    chk("acq_no_lock_state", state, 1);
    chk("acq_good_cnt", good_cnt, 2);
    chk("acq_locked", locked, 0);
    // 6: output disabled while locked, then async reset mid-pulse
    lock_seq(2'd2);
    run_to(500);
    mode = 2'd1;
    et(553, 2, 1, 3, 100, 1);
    run_to(554);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_pps_out", pps_out, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_period", period_meas, 0);
    chk("async_rst_good_cnt", good_cnt, 0);
    drain_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
